fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RSTn.
REQ-002 The block SHALL have a parameter: DEPTH, default 4, entry count (power of two, minimum 2).
REQ-003 The block SHALL have a parameter: NOP_INSTR, default 32'h00000013, instruction driven when output is invalid.
REQ-004 The block SHALL have the port: CLK  input  1  rising-edge clock.
REQ-005 The block SHALL have the port: RSTn  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have the port: flush  input  1  branch taken; discard all entries.
REQ-007 The block SHALL have the port: in_valid  input  1  fetch stage offers {in_pc, in_instr}.
REQ-008 The block SHALL have the port: in_pc  input  32  PC of offered instruction.
REQ-009 The block SHALL have the port: in_instr  input  32  instruction word from instruction memory.
REQ-010 The block SHALL have the port: in_ready  output  1  queue can accept; its inverse drives the fetch stage stall input.
REQ-011 The block SHALL have the port: out_valid  output  1  entry available to decode.
REQ-012 The block SHALL have the port: out_pc  output  32  PC of head entry.
REQ-013 The block SHALL have the port: out_instr  output  32  instruction of head entry.
REQ-014 The block SHALL have the port: out_ready  input  1  decode consumes head this cycle.
REQ-015 The block SHALL have the port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 The block SHALL perform a push when in_valid && in_ready && !flush, and a pop when out_valid && out_ready && !flush.
REQ-017 The block SHALL drive in_ready = (count != DEPTH), registered-state only, with no combinational dependence on out_ready.
REQ-018 When the queue is full, the block SHALL block a push even if a pop occurs in the same cycle.
REQ-019 The block SHALL maintain occupancy state EMPTY (count 0), PARTIAL (0<count<DEPTH) and FULL (count DEPTH).
REQ-020 On push-only, count SHALL increment; on pop-only, count SHALL decrement; on simultaneous push and pop, count SHALL be unchanged.
REQ-021 Write and read pointers SHALL be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-022 Output SHALL be in FIFO order.
REQ-023 out_pc and out_instr SHALL be the head entry when out_valid is 1.
REQ-024 out_pc SHALL be 0 and out_instr SHALL be NOP_INSTR when out_valid is 0.
REQ-025 Without bypass, latency SHALL be 1 cycle: an entry pushed at edge N is visible at out_* after edge N.
REQ-026 flush SHALL have priority: at the next edge, count, wr_ptr and rd_ptr SHALL become 0; any same-cycle push or pop SHALL be discarded.
REQ-027 During the flush cycle, out_valid SHALL remain as registered; decode ignores it under branch.
REQ-028 A push while flush is asserted SHALL be lost; the new branch target is re-fetched.

Reset
REQ-029 While RSTn is 0, regardless of CLK, count, wr_ptr and rd_ptr SHALL be 0, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-030 While RSTn is 0, out_pc SHALL be 0 and out_instr SHALL be NOP_INSTR.
REQ-031 Storage contents SHALL need no reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately.

Configuration
REQ-033 When FETCH_QUEUE_BYPASS_EN is defined and the queue is EMPTY, in_valid && !flush SHALL drive out_valid=1 with out_pc/out_instr taken from in_pc/in_instr combinationally.
REQ-034 When FETCH_QUEUE_BYPASS_EN is defined and bypass applies, out_ready=1 in the same cycle SHALL consume the entry without storing it and count SHALL stay 0.
REQ-035 When FETCH_QUEUE_BYPASS_EN is defined and bypass applies but out_ready=0, the entry SHALL be stored normally.
REQ-036 When FETCH_QUEUE_BYPASS_EN is undefined, REQ-025 latency SHALL apply and no combinational path SHALL exist from in_* to out_*.

Structure
REQ-037 Shared package SHALL hold NOP_INSTR, an XLEN=32 constant and a typedef for the {pc, instr} entry.
REQ-038 One sub-module SHALL be used: fetch_queue_mem, a DEPTH x 64-bit register array with one write port and one asynchronous read port.
REQ-039 Pointer, count and handshake logic SHALL reside in fetch_queue.

Verification
REQ-040 Reset then idle SHALL yield out_valid=0, out_instr=32'h00000013, in_ready=1, count=0.
REQ-041 Pushing PCs 0,4,8,12 with out_ready=0 SHALL yield count=4, in_ready=0; a 5th push SHALL be rejected; then out_ready=1 for 4 cycles SHALL pop 0,4,8,12 in order.
REQ-042 With count=2 and simultaneous push(PC 16)/pop every cycle for 10 cycles, count SHALL stay 2 and order SHALL be preserved across pointer wrap.
REQ-043 With count=3, flush asserted together with in_valid (PC 0x100) SHALL give count=0 and out_valid=0 next cycle; PC 0x100 SHALL never appear.
REQ-044 With FETCH_QUEUE_BYPASS_EN, queue empty, in_valid and out_ready with PC 0x40 SHALL give out_pc=0x40 in the same cycle and count=0; without the macro, out_pc=0x40 SHALL appear one cycle later.
REQ-045 RSTn asserted with count=3 SHALL make out_valid 0 and count 0 before the next CLK edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: XLEN, the NOP encoding,
// the stored {pc, instr} entry and the occupancy state encoding.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } fq_occ_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x 64-bit register array,
// one synchronous write port and one asynchronous read port, no reset.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fq_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output fq_entry_t       rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode with flush on branch.
// Define FETCH_QUEUE_BYPASS_EN to forward an offered entry straight to decode when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_queue_pkg::NOP_INSTR
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fq_occ_e       occ_q, occ_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          head_valid;
  logic          push_req, pop_req, bypass_hit;
  logic          push, pop;
  fq_entry_t     wr_entry, rd_entry;

  assign head_valid = (occ_q != OCC_EMPTY);
  assign in_ready   = (occ_q != OCC_FULL);
  assign count      = cnt_q;

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_comb begin
    out_valid = head_valid;
    out_pc    = '0;
    out_instr = NOP_INSTR;
    if (head_valid) begin
      out_pc    = rd_entry.pc;
      out_instr = rd_entry.instr;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (in_valid && !flush) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
`endif
  end

  assign push_req = in_valid && in_ready && !flush;
  assign pop_req  = out_valid && out_ready && !flush;

  // A pop with an empty queue can only be a bypassed entry: it is consumed
  // in flight, so neither the storage nor the pointers move. Never true
  // without bypass, since out_valid then implies a stored head.
  assign bypass_hit = !head_valid && push_req && pop_req;
  assign push       = push_req && !bypass_hit;
  assign pop        = pop_req && !bypass_hit;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end

    occ_d = OCC_PARTIAL;
    if (cnt_d == '0) begin
      occ_d = OCC_EMPTY;
    end else if (cnt_d == FULL_CNT) begin
      occ_d = OCC_FULL;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      occ_q  <= OCC_EMPTY;
      cnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      occ_q  <= OCC_EMPTY;
      cnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule
